axis_result_sink: RTL
=====================

# axis_result_sink

Synthesizable AXI4-Stream sink that terminates the result stream leaving `SA3D_Top` on its `m_axis_mm2s_*` port. It captures one output frame (beats up to and including `tlast`) into an internal buffer and checks frame length and `tkeep` against an expected beat count. It then exposes the frame through a one-cycle-latency read port and pulses `done` so a controller can re-arm the array with `Control_start`.

## Interface
- `DATA_W`, 64, stream and buffer word width (multiple of 8)
- `ADDR_W`, 12, buffer address width; depth = 2^ADDR_W words
- `clk`  in  1  sole clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse: arm capture, clear counters and flags
- `expected_beats`  in  ADDR_W+1  frame length in beats, sampled on `start`
- `s_axis_tdata`  in  DATA_W  stream data
- `s_axis_tkeep`  in  DATA_W/8  byte enables
- `s_axis_tvalid`  in  1  upstream data valid
- `s_axis_tlast`  in  1  last beat of frame
- `s_axis_tready`  out  1  sink ready
- `busy`  out  1  high while in CAPTURE
- `done`  out  1  one-cycle pulse on frame completion
- `beat_count`  out  ADDR_W+1  beats accepted in current or last frame
- `err_len`  out  1  `tlast` beat index ≠ `expected_beats`
- `err_overflow`  out  1  beats arrived after buffer was full
- `err_keep`  out  1  non-last beat with `tkeep` not all ones
- `rd_addr`  in  ADDR_W  buffer read address
- `rd_data`  out  DATA_W  registered read data
- `checksum`  out  DATA_W  running XOR of accepted beats (only with `SINK_CHECKSUM_EN`)

## Operation
- States: IDLE, CAPTURE, DONE. Reset → IDLE.
- IDLE/DONE + `start` → CAPTURE. Latch `expected_beats`. Clear `beat_count`, write pointer, all `err_*`, and `checksum`.
- CAPTURE + `start` → abort the frame and re-arm as above. Any beat presented in that cycle is dropped.
- `s_axis_tready` = (state==CAPTURE). The block never backpressures mid-frame.
- Accept = `tvalid && tready`. On accept:
  - if `beat_count < 2^ADDR_W`, write `tdata` at `beat_count`;
  - else discard the data and set `err_overflow`.
  - `beat_count` increments, saturating at all-ones.
- Accept with `tkeep != all-ones` and `!tlast` sets `err_keep`.
- Accept with `tlast`: compare (`beat_count`+1) against the latched expected value and set `err_len` on mismatch. Go to DONE and pulse `done` on the next cycle.
- If `beat_count` reaches the expected value without `tlast`, capture continues. `err_len` is set when `tlast` finally arrives.
- Error flags are sticky until the next `start` or `reset`.
- The read port works in every state. A read at address ≥ `beat_count` returns stale buffer contents, which are not cleared.

## Timing
- Reset values:
  - `s_axis_tready` 0, `busy` 0, `done` 0;
  - `beat_count` 0, all `err_*` 0, `checksum` 0, `rd_data` 0;
  - buffer contents undefined.
- `start` at edge N: `tready` and `busy` go high after edge N and the first beat can be accepted at edge N+1.
- `tlast` accepted at edge N: `tready`/`busy` drop and `done`=1 for the single cycle after edge N. Flags and `beat_count` are final in that same cycle.
- `rd_data` reflects `rd_addr` sampled at edge N, valid after edge N (1-cycle latency). A same-cycle write and read to one address returns the old data.
- `start` coincident with an accepted `tlast`: `start` wins. No `done` is pulsed and the state is CAPTURE.
- `reset` mid-frame: immediate return to IDLE with reset values and no `done`.

## Configuration
- `SINK_CHECKSUM_EN` defined:
  - `checksum` port exists;
  - XOR-accumulates `tdata` of every accepted beat, including overflowed beats;
  - cleared on `start`/`reset`.
- Undefined: the `checksum` port and its register are absent. All other behaviour is identical.

## Test plan
- **Nominal frame:** `start`, `expected_beats`=196, 196 beats of data k with `tlast` on beat 196 → `done` pulse one cycle after the last beat; `beat_count`=196; no errors; `rd_addr`=k returns k.
- **Short frame:** `expected_beats`=8, `tlast` on beat 5 → `err_len`=1, `beat_count`=5, `done` pulses.
- **Overflow (`ADDR_W`=4):** 20 beats, `tlast` on beat 20 → `err_overflow`=1; words 0–15 intact; `beat_count`=20.
- **Keep check:** `tkeep`=8'h0F on beat 3 (not last), and `tkeep`=8'h0F on the last beat of a second frame → `err_keep`=1 only in the first frame.
- **Restart and abort:** `start` mid-frame after 10 beats, then a full 16-beat frame → `beat_count`=16, no errors; `start` coincident with `tlast` → no `done`, `busy`=1.
- **Checksum (`SINK_CHECKSUM_EN`):** beats 0x1, 0x2, 0x4 → `checksum`=0x7; async `reset` mid-frame → all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/axis_result_sink.sv
// AXI4-Stream result sink: captures one frame into a buffer, checks length/tkeep, exposes it on a registered read port.
// Define SINK_CHECKSUM_EN to add the running XOR checksum output.
module axis_result_sink #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W:0]       expected_beats,
   input  logic [DATA_W-1:0]     s_axis_tdata,
   input  logic [DATA_W/8-1:0]   s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W:0]       beat_count,
   output logic                  err_len,
   output logic                  err_overflow,
   output logic                  err_keep,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data
`ifdef SINK_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]     checksum
`endif
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   BC_MAX = {(ADDR_W+1){1'b1}};
   localparam logic [ADDR_W:0]   BC_ONE = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                tready_q, tready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [ADDR_W:0]     beat_count_q, beat_count_d;
   logic [ADDR_W:0]     exp_beats_q, exp_beats_d;
   logic                err_len_q, err_len_d;
   logic                err_overflow_q, err_overflow_d;
   logic                err_keep_q, err_keep_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic [DATA_W-1:0]   buf_mem [DEPTH];

   logic                accept_s;
   logic                wr_en_s;
   logic [ADDR_W+1:0]   last_idx_s;

   // A start in the same cycle as a beat wins: the beat is dropped.
   assign accept_s   = s_axis_tvalid && tready_q && !start;
   assign wr_en_s    = accept_s && !beat_count_q[ADDR_W];
   assign last_idx_s = {1'b0, beat_count_q} + {1'b0, BC_ONE};

   // Next-state and flag computation for the capture FSM.
   always_comb begin
      state_d        = state_q;
      tready_d       = tready_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      beat_count_d   = beat_count_q;
      exp_beats_d    = exp_beats_q;
      err_len_d      = err_len_q;
      err_overflow_d = err_overflow_q;
      err_keep_d     = err_keep_q;
      if (start) begin
         state_d        = ST_CAPTURE;
         tready_d       = 1'b1;
         busy_d         = 1'b1;
         exp_beats_d    = expected_beats;
         beat_count_d   = {(ADDR_W+1){1'b0}};
         err_len_d      = 1'b0;
         err_overflow_d = 1'b0;
         err_keep_d     = 1'b0;
      end else if (accept_s) begin
         if (beat_count_q != BC_MAX) begin
            beat_count_d = beat_count_q + BC_ONE;
         end else begin
            beat_count_d = beat_count_q;
         end
         if (beat_count_q[ADDR_W]) begin
            err_overflow_d = 1'b1;
         end else begin
            err_overflow_d = err_overflow_q;
         end
         if (!s_axis_tlast && (s_axis_tkeep != {KEEP_W{1'b1}})) begin
            err_keep_d = 1'b1;
         end else begin
            err_keep_d = err_keep_q;
         end
         if (s_axis_tlast) begin
            err_len_d = err_len_q | (last_idx_s != {1'b0, exp_beats_q});
            state_d   = ST_DONE;
            tready_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
         end else begin
            state_d   = state_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // Read port is live in every state; unwritten words read back stale.
   always_comb begin
      rd_data_d = buf_mem[rd_addr];
   end

   // Control, status and read-data registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         tready_q       <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         beat_count_q   <= {(ADDR_W+1){1'b0}};
         exp_beats_q    <= {(ADDR_W+1){1'b0}};
         err_len_q      <= 1'b0;
         err_overflow_q <= 1'b0;
         err_keep_q     <= 1'b0;
         rd_data_q      <= {DATA_W{1'b0}};
      end else begin
         state_q        <= state_d;
         tready_q       <= tready_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         beat_count_q   <= beat_count_d;
         exp_beats_q    <= exp_beats_d;
         err_len_q      <= err_len_d;
         err_overflow_q <= err_overflow_d;
         err_keep_q     <= err_keep_d;
         rd_data_q      <= rd_data_d;
      end
   end

   // Frame buffer: no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         buf_mem[beat_count_q[ADDR_W-1:0]] <= s_axis_tdata;
      end
   end

`ifdef SINK_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q, checksum_d;

   // Checksum folds in every accepted beat, including ones past the end of the buffer.
   always_comb begin
      if (start) begin
         checksum_d = {DATA_W{1'b0}};
      end else if (accept_s) begin
         checksum_d = checksum_q ^ s_axis_tdata;
      end else begin
         checksum_d = checksum_q;
      end
   end

   // Checksum register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         checksum_q <= {DATA_W{1'b0}};
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`endif

   assign s_axis_tready = tready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign beat_count    = beat_count_q;
   assign err_len       = err_len_q;
   assign err_overflow  = err_overflow_q;
   assign err_keep      = err_keep_q;
   assign rd_data       = rd_data_q;

endmodule
